// File: rtl/game_flow_ctrl.sv
// Screen sequencer for the digit-counter game: key edge detection, screen FSM,
// slot count / cursor selection, mod-10 digit editing and the beep timer.
module game_flow_ctrl #(
   parameter int unsigned SLOTS       = 10,
   parameter logic [3:0]  INIT_DIGIT  = 4'h1,
   parameter int unsigned BEEP_CYCLES = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] btn,
   output logic [1:0]  state,
   output logic [3:0]  num,
   output logic [3:0]  cursor,
   output logic [39:0] status,
   output logic        beep
);

   localparam int unsigned CntW = (BEEP_CYCLES < 2) ? 1 : $clog2(BEEP_CYCLES + 1);

   localparam int unsigned KeyHelp    = 15;
   localparam int unsigned KeyNext    = 14;
   localparam int unsigned KeyBack    = 13;
   localparam int unsigned KeyExit    = 12;
   localparam int unsigned KeyConfirm = 10;
   localparam int unsigned KeyUp      = 2;
   localparam int unsigned KeyDown    = 6;
   localparam int unsigned KeyLeft    = 7;
   localparam int unsigned KeyRight   = 5;

   typedef enum logic [1:0] {
      StStart  = 2'b00,
      StHelp   = 2'b01,
      StChoose = 2'b10,
      StPlay   = 2'b11
   } state_e;

   function automatic logic [39:0] init_status();
      logic [39:0] s;
      s = '0;
      for (int i = 0; i < 10; i++) begin
         if (i < int'(SLOTS)) s[4*i +: 4] = INIT_DIGIT;
      end
      return s;
   endfunction

   localparam logic [39:0] StatusInit = init_status();

   state_e          state_q, state_d;
   logic [3:0]      num_q, num_d;
   logic [3:0]      cursor_q, cursor_d;
   logic [39:0]     status_q, status_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [15:0]     btn_q;
   logic [15:0]     press;

   logic [3:0] cur_digit;
   logic [3:0] new_digit;
   logic       digit_we;
   logic       unused_keys;

   assign press       = btn & ~btn_q;
   assign unused_keys = ^{press[11], press[9:8], press[4:3], press[1:0]};

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      cursor_d  = cursor_q;
      status_d  = status_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      new_digit = 4'h0;
      digit_we  = 1'b0;

      cur_digit = 4'h0;
      for (int i = 0; i < 10; i++) begin
         if (4'(i) == cursor_q) cur_digit = status_q[4*i +: 4];
      end

      case (state_q)
         StStart: begin
            if (press[KeyHelp])      state_d = StHelp;
            else if (press[KeyNext]) state_d = StChoose;
         end
         StHelp: begin
            if (press[KeyBack])      state_d = StStart;
            else if (press[KeyNext]) state_d = StChoose;
         end
         StChoose: begin
            if (press[KeyExit]) begin
               state_d = StStart;
            end else if (press[KeyNext] || press[KeyConfirm]) begin
               state_d  = StPlay;
               cursor_d = 4'd0;
               cnt_d    = '0;
               for (int i = 0; i < 10; i++) begin
                  if (4'(i) < num_q) status_d[4*i +: 4] = INIT_DIGIT;
               end
            end else if (press[KeyUp]) begin
               num_d = (num_q == 4'(SLOTS)) ? 4'd1 : num_q + 4'd1;
            end else if (press[KeyDown]) begin
               num_d = (num_q == 4'd1) ? 4'(SLOTS) : num_q - 4'd1;
            end
         end
         StPlay: begin
            if (press[KeyExit]) begin
               state_d  = StStart;
               num_d    = 4'd1;
               cursor_d = 4'd0;
               status_d = StatusInit;
               cnt_d    = '0;
            end else if (press[KeyRight]) begin
               cursor_d = (cursor_q == num_q - 4'd1) ? 4'd0 : cursor_q + 4'd1;
            end else if (press[KeyLeft]) begin
               cursor_d = (cursor_q == 4'd0) ? num_q - 4'd1 : cursor_q - 4'd1;
            end else if (press[KeyUp]) begin
               digit_we = 1'b1;
               if (cur_digit == 4'd9) begin
                  new_digit = 4'd0;
                  // A wrap restarts the full beep rather than extending it.
                  cnt_d     = CntW'(BEEP_CYCLES);
               end else begin
                  new_digit = cur_digit + 4'd1;
               end
            end else if (press[KeyDown]) begin
               digit_we  = 1'b1;
               new_digit = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
            end
         end
         default: state_d = StStart;
      endcase

      if (digit_we) begin
         for (int i = 0; i < 10; i++) begin
            if (4'(i) == cursor_q) status_d[4*i +: 4] = new_digit;
         end
      end

      for (int i = 0; i < 10; i++) begin
         if (i >= int'(SLOTS)) status_d[4*i +: 4] = 4'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StStart;
         num_q    <= 4'd1;
         cursor_q <= 4'd0;
         status_q <= StatusInit;
         cnt_q    <= '0;
         // Keys held through reset must not fire once reset drops.
         btn_q    <= 16'hFFFF;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         cursor_q <= cursor_d;
         status_q <= status_d;
         cnt_q    <= cnt_d;
         btn_q    <= btn;
      end
   end

   assign state  = state_q;
   assign num    = num_q;
   assign cursor = cursor_q;
   assign status = status_q;
   assign beep   = (cnt_q != '0);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short beep length.
module tb_game_flow_ctrl;

   localparam int unsigned Beep = 20;

   localparam logic [15:0] KHelp    = 16'h8000;
   localparam logic [15:0] KNext    = 16'h4000;
   localparam logic [15:0] KBack    = 16'h2000;
   localparam logic [15:0] KExit    = 16'h1000;
   localparam logic [15:0] KConfirm = 16'h0400;
   localparam logic [15:0] KUp      = 16'h0004;
   localparam logic [15:0] KDown    = 16'h0040;
   localparam logic [15:0] KLeft    = 16'h0080;
   localparam logic [15:0] KRight   = 16'h0020;

   localparam logic [39:0] StInit = 40'h1111111111;

   logic        clk;
   logic        rst;
   logic [15:0] btn;
   logic [1:0]  state;
   logic [3:0]  num;
   logic [3:0]  cursor;
   logic [39:0] status;
   logic        beep;

   int n_checks;
   int n_fail;
   int hi;

   game_flow_ctrl #(
      .SLOTS       (10),
      .INIT_DIGIT  (4'h1),
      .BEEP_CYCLES (Beep)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn),
      .state  (state),
      .num    (num),
      .cursor (cursor),
      .status (status),
      .beep   (beep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Press for one cycle then release for one cycle; ends on a negedge.
   task automatic tap(input logic [15:0] b);
      btn = b;
      @(negedge clk);
      btn = '0;
      @(negedge clk);
   endtask

   // Drive one cycle and count it if beep is high afterwards.
   task automatic step_cnt(input logic [15:0] b);
      btn = b;
      @(negedge clk);
      if (beep) hi++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      btn      = KNext;
      repeat (5) @(negedge clk);
      check("rst_state", 64'(state), 64'h0);
      check("rst_num", 64'(num), 64'd1);
      check("rst_cursor", 64'(cursor), 64'd0);
      check("rst_status", 64'(status), 64'(StInit));
      check("rst_beep", 64'(beep), 64'd0);

      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("held_next_no_fire", 64'(state), 64'h0);
      btn = '0;
      @(negedge clk);
      tap(KNext);
      check("start_next", 64'(state), 64'h2);
      tap(KExit);
      check("choose_exit", 64'(state), 64'h0);

      tap(KHelp);
      check("start_help", 64'(state), 64'h1);
      tap(KBack);
      check("help_back", 64'(state), 64'h0);
      tap(KHelp | KNext);
      check("help_wins", 64'(state), 64'h1);
      tap(KNext);
      check("help_next", 64'(state), 64'h2);

      tap(KDown);
      check("num_down_wrap", 64'(num), 64'd10);
      tap(KUp);
      check("num_up_wrap", 64'(num), 64'd1);
      repeat (3) tap(KUp);
      check("num_up3", 64'(num), 64'd4);
      tap(KConfirm);
      check("play_state", 64'(state), 64'h3);
      check("play_cursor", 64'(cursor), 64'd0);
      check("play_status_lo", 64'(status[15:0]), 64'h1111);

      tap(KLeft);
      check("left_wrap", 64'(cursor), 64'd3);
      tap(KRight);
      check("right_wrap", 64'(cursor), 64'd0);
      repeat (8) tap(KUp);
      check("slot0_at9", 64'(status[3:0]), 64'd9);
      check("no_beep_before", 64'(beep), 64'd0);
      hi = 0;
      step_cnt(KUp);
      check("beep_rise", 64'(beep), 64'd1);
      check("slot0_wrap", 64'(status[3:0]), 64'd0);
      for (int g = 0; g < 200 && beep; g++) step_cnt('0);
      check("beep_len", 64'(hi), 64'(Beep));
      check("beep_end", 64'(beep), 64'd0);

      tap(KConfirm);
      check("confirm_ignored", 64'(state), 64'h3);
      tap(KRight);
      tap(KDown);
      tap(KDown);
      check("slot1_down_wrap", 64'(status[7:4]), 64'd9);
      check("down_no_beep", 64'(beep), 64'd0);
      tap(KRight);
      tap(KDown);
      tap(KDown);
      tap(KLeft);
      check("cursor1", 64'(cursor), 64'd1);
      check("status_prep", 64'(status), 64'h1111111990);

      hi = 0;
      step_cnt(KUp);
      repeat (8) step_cnt('0);
      step_cnt(KRight);
      check("half_count", 64'(hi), 64'd10);
      step_cnt(KUp);
      for (int g = 0; g < 200 && beep; g++) step_cnt('0);
      check("beep_restart_len", 64'(hi), 64'(10 + Beep));
      check("status_restart", 64'(status), 64'h1111111000);

      tap(KDown);
      step_cnt(KUp);
      check("beep_again", 64'(beep), 64'd1);
      repeat (3) step_cnt('0);
      step_cnt(KExit);
      check("exit_state", 64'(state), 64'h0);
      check("exit_status", 64'(status), 64'(StInit));
      check("exit_num", 64'(num), 64'd1);
      check("exit_cursor", 64'(cursor), 64'd0);
      check("exit_beep", 64'(beep), 64'd0);

      btn = '0;
      @(negedge clk);
      tap(KNext);
      check("reenter_num", 64'(num), 64'd1);
      tap(KConfirm);
      tap(KDown);
      tap(KDown);
      check("slot0_9", 64'(status[3:0]), 64'd9);
      step_cnt(KUp);
      check("beep_pre_rst", 64'(beep), 64'd1);
      repeat (2) step_cnt('0);
      rst = 1'b1;
      btn = KUp;
      @(negedge clk);
      check("rstmid_state", 64'(state), 64'h0);
      check("rstmid_status", 64'(status), 64'(StInit));
      check("rstmid_num", 64'(num), 64'd1);
      check("rstmid_cursor", 64'(cursor), 64'd0);
      check("rstmid_beep", 64'(beep), 64'd0);
      rst = 1'b0;
      btn = '0;
      @(negedge clk);
      check("post_rst_state", 64'(state), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
